// File: rtl/seq_encoder8to3.sv
// Sequential 8-to-3 priority encoder: captures a request vector and streams the
// index of every set bit, one per valid/ready handshake, in priority order.
module seq_encoder8to3 #(
  parameter bit PRIORITY_MSB = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  output logic       busy,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ready,
  output logic       done,
  output logic [3:0] count
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t     state;
  logic [7:0] pending;
  logic [7:0] pend_next;
  logic       hs;

  // Later matches overwrite earlier ones, so the scan direction picks the winner.
  function automatic logic [2:0] prio_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (PRIORITY_MSB) begin
      for (int i = 0; i < 8; i++)
        if (v[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    hs        = valid && ready;
    pend_next = pending & ~(8'd1 << code);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 8'd0;
      count   <= 4'd0;
      code    <= 3'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (load) begin
            pending <= din;
            count   <= 4'd0;
            busy    <= 1'b1;
            if (din != 8'd0) begin
              code  <= prio_index(din);
              valid <= 1'b1;
              state <= EMIT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        EMIT: begin
          // Stalled cycles fall through with code, valid and pending untouched.
          if (hs) begin
            pending <= pend_next;
            count   <= count + 4'd1;
            if (pend_next == 8'd0) begin
              valid <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              code <= prio_index(pend_next);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_encoder8to3.sv
// Directed bench for seq_encoder8to3: one descending and one ascending instance.
module tb_seq_encoder8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, ready, load_l, ready_l;
  logic [7:0] din, din_l;
  logic       busy, valid, done, busy_l, valid_l, done_l;
  logic [2:0] code, code_l;
  logic [3:0] count, count_l;
  int         pass_cnt = 0;
  int         total    = 0;

  always #5 clk = ~clk;

  seq_encoder8to3 #(.PRIORITY_MSB(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din), .busy(busy),
    .code(code), .valid(valid), .ready(ready), .done(done), .count(count)
  );

  seq_encoder8to3 #(.PRIORITY_MSB(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load(load_l), .din(din_l), .busy(busy_l),
    .code(code_l), .valid(valid_l), .ready(ready_l), .done(done_l), .count(count_l)
  );

  // Observation vector: {valid, busy, done, code[2:0], count[3:0]}
  logic [9:0] obs, obs_l;
  assign obs   = {valid, busy, done, code, count};
  assign obs_l = {valid_l, busy_l, done_l, code_l, count_l};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; din = 8'hFF; ready = 1'b1;
    load_l = 1'b1; din_l = 8'hA5; ready_l = 1'b1;
    repeat (2) tick();
    total++;
    if (obs !== 10'd0) $display("FAIL reset_msb got %b want %b", obs, 10'd0);
    else pass_cnt++;
    total++;
    if (obs_l !== 10'd0) $display("FAIL reset_lsb got %b want %b", obs_l, 10'd0);
    else pass_cnt++;
    load = 1'b0; load_l = 1'b0; ready = 1'b0; ready_l = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== 10'd0 || obs_l !== 10'd0)
        $display("FAIL reset_idle%0d got %b/%b want %b", i, obs, obs_l, 10'd0);
      else pass_cnt++;
    end
  endtask

  task automatic test_stream();
    logic [9:0] exp_v [5];
    exp_v = '{{3'b110, 3'd7, 4'd0}, {3'b110, 3'd5, 4'd1}, {3'b110, 3'd2, 4'd2},
              {3'b011, 3'd2, 4'd3}, {3'b000, 3'd2, 4'd3}};
    load = 1'b1; din = 8'b1010_0100; ready = 1'b1;
    tick();
    load = 1'b0; din = 8'h00;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs !== exp_v[i]) $display("FAIL stream_c%0d got %b want %b", i, obs, exp_v[i]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int         exp_code;
    int         hs;
    pat = 4'b1001;
    exp_code = 7;
    hs = 0;
    load = 1'b1; din = 8'hFF; ready = 1'b0;
    tick();
    load = 1'b0;
    for (int cyc = 0; cyc < 40 && hs < 8; cyc++) begin
      total++;
      if (obs !== {3'b110, 3'(exp_code), 4'(7 - exp_code)})
        $display("FAIL bp_cyc%0d got %b want %b", cyc, obs, {3'b110, 3'(exp_code), 4'(7 - exp_code)});
      else pass_cnt++;
      ready = pat[cyc % 4];
      tick();
      if (ready) begin
        exp_code--;
        hs++;
      end
    end
    ready = 1'b0;
    total++;
    if (hs != 8) $display("FAIL bp_timeout got %0d handshakes want 8", hs);
    else pass_cnt++;
    total++;
    if (obs !== {3'b011, 3'd0, 4'd8}) $display("FAIL bp_done got %b want %b", obs, {3'b011, 3'd0, 4'd8});
    else pass_cnt++;
    tick();
    total++;
    if (obs !== {3'b000, 3'd0, 4'd8}) $display("FAIL bp_idle got %b want %b", obs, {3'b000, 3'd0, 4'd8});
    else pass_cnt++;
  endtask

  task automatic test_ascending();
    logic [9:0] exp_v [4];
    exp_v = '{{3'b110, 3'd0, 4'd0}, {3'b110, 3'd7, 4'd1},
              {3'b011, 3'd7, 4'd2}, {3'b000, 3'd7, 4'd2}};
    load_l = 1'b1; din_l = 8'b1000_0001; ready_l = 1'b1;
    tick();
    load_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_l !== exp_v[i]) $display("FAIL asc_c%0d got %b want %b", i, obs_l, exp_v[i]);
      else pass_cnt++;
      tick();
    end
    ready_l = 1'b0;
  endtask

  task automatic test_empty();
    load = 1'b1; din = 8'h00; ready = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (obs !== {3'b011, 3'd0, 4'd0}) $display("FAIL empty_done got %b want %b", obs, {3'b011, 3'd0, 4'd0});
    else pass_cnt++;
    tick();
    total++;
    if (obs !== {3'b000, 3'd0, 4'd0}) $display("FAIL empty_idle got %b want %b", obs, {3'b000, 3'd0, 4'd0});
    else pass_cnt++;
    ready = 1'b0;
  endtask

  task automatic test_load_while_busy();
    load = 1'b1; din = 8'h10; ready = 1'b0;
    tick();
    total++;
    if (obs !== {3'b110, 3'd4, 4'd0}) $display("FAIL lwb_first got %b want %b", obs, {3'b110, 3'd4, 4'd0});
    else pass_cnt++;
    din = 8'hFF;
    tick();
    total++;
    if (obs !== {3'b110, 3'd4, 4'd0}) $display("FAIL lwb_emit got %b want %b", obs, {3'b110, 3'd4, 4'd0});
    else pass_cnt++;
    load = 1'b0; ready = 1'b1;
    tick();
    total++;
    if (obs !== {3'b011, 3'd4, 4'd1}) $display("FAIL lwb_done got %b want %b", obs, {3'b011, 3'd4, 4'd1});
    else pass_cnt++;
    load = 1'b1;
    tick();
    load = 1'b0; din = 8'h00;
    total++;
    if (obs !== {3'b000, 3'd4, 4'd1}) $display("FAIL lwb_ign got %b want %b", obs, {3'b000, 3'd4, 4'd1});
    else pass_cnt++;
    tick();
    total++;
    if (obs !== {3'b000, 3'd4, 4'd1}) $display("FAIL lwb_idle got %b want %b", obs, {3'b000, 3'd4, 4'd1});
    else pass_cnt++;
    ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    load = 1'b1; din = 8'hF0; ready = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (obs !== {3'b110, 3'd7, 4'd0}) $display("FAIL rms_first got %b want %b", obs, {3'b110, 3'd7, 4'd0});
    else pass_cnt++;
    tick();
    ready = 1'b0;
    total++;
    if (obs !== {3'b110, 3'd6, 4'd1}) $display("FAIL rms_second got %b want %b", obs, {3'b110, 3'd6, 4'd1});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 10'd0) $display("FAIL rms_async got %b want %b", obs, 10'd0);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs !== 10'd0) $display("FAIL rms_nodone%0d got %b want %b", i, obs, 10'd0);
      else pass_cnt++;
    end
    load = 1'b1; din = 8'h01; ready = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (obs !== {3'b110, 3'd0, 4'd0}) $display("FAIL rms_reload got %b want %b", obs, {3'b110, 3'd0, 4'd0});
    else pass_cnt++;
    tick();
    total++;
    if (obs !== {3'b011, 3'd0, 4'd1}) $display("FAIL rms_redone got %b want %b", obs, {3'b011, 3'd0, 4'd1});
    else pass_cnt++;
    tick();
    total++;
    if (obs !== {3'b000, 3'd0, 4'd1}) $display("FAIL rms_reidle got %b want %b", obs, {3'b000, 3'd0, 4'd1});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_ascending();
    test_empty();
    test_load_while_busy();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/seq_encoder8to3.md
# seq_encoder8to3

Sequential 8-to-3 priority encoder: the inverse of the team's 3-to-8 function decoder. It captures an 8-bit request vector and streams the 3-bit index of every set bit, one per handshake, in priority order, over a valid/ready interface. It sits after request-collection logic and feeds a downstream consumer that takes one encoded index at a time.

## Interface
- PRIORITY_MSB, default 1: 1 = bit 7 serviced first (descending); 0 = bit 0 first (ascending).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  capture din when the block is idle.
- din  in  8  request vector; multi-hot allowed.
- busy  out  1  high from the accepted load until done completes.
- code  out  3  index of the current highest-priority pending bit.
- valid  out  1  code is valid.
- ready  in  1  consumer accepts code when valid && ready at a rising edge.
- done  out  1  one-cycle pulse after the last code is accepted, or after an empty load.
- count  out  4  number of codes accepted since the last load, 0..8.

## Operation
- Internal state: pending[7:0] register, FSM {IDLE, EMIT, DONE}, count register.
- Reset (async, rst_n=0): FSM=IDLE, pending=0, count=0, code=0, valid=0, busy=0, done=0.
- IDLE: if load=1 at an edge, pending<=din, count<=0, busy<=1. Next state is EMIT if din!=0, else DONE.
- EMIT: valid=1. code = index of the highest set bit of pending (PRIORITY_MSB=1) or the lowest set bit (PRIORITY_MSB=0). Both are registered, glitch-free outputs.
  - valid && ready at an edge: clear that bit in pending, count<=count+1, and update code to the next index in the same edge.
  - If the cleared bit was the last one: next state DONE, valid<=0.
  - valid && !ready: code, valid and pending are held stable (no change while stalled).
- DONE: done=1 for exactly one cycle, busy=1, valid=0. Next state is IDLE, where busy<=0 and done<=0.
- load outside IDLE (EMIT or DONE) is ignored; din is not sampled.
- count saturates naturally at 8 (at most 8 bits set). It holds its value after done until the next accepted load.
- code holds its last value while valid=0; consumers must ignore it.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and no done pulse is issued.

## Timing
- Accepted load at edge N (din!=0): busy=1 and valid=1 from cycle N+1; the first code appears at N+1.
- With ready held high, one code is accepted per cycle, back-to-back: k set bits give handshakes at edges N+1..N+k.
- The last handshake at edge M gives valid=0 and done=1 in cycle M+1. Edge M+1 returns to IDLE; busy=0 and done=0 from M+2.
- A new load is accepted at the earliest at edge M+2, i.e. the first IDLE cycle.
- Empty load (din=0) at edge N: valid never asserts, done=1 and busy=1 in cycle N+1, count=0, IDLE from N+2.
- All outputs are registered. There is no combinational path from ready or load to any output.

## Test plan
- Reset: assert rst_n=0 with arbitrary inputs -> valid=0, busy=0, done=0, code=0, count=0. Release, idle for 3 cycles -> outputs unchanged.
- Stream: PRIORITY_MSB=1, load din=8'b1010_0100, ready=1 -> code 7,5,2 on three consecutive valid cycles, then a done pulse, count=3, busy low 2 cycles after the last handshake.
- Backpressure: din=8'hFF, ready toggling 1,0,0,1,... -> code is stable through every stall and the sequence is 7,6,5,4,3,2,1,0 with no skips or repeats; count=8.
- Ascending and edge cases: PRIORITY_MSB=0 with din=8'b1000_0001 -> codes 0 then 7. din=8'h00 -> no valid, done one cycle after load, count=0.
- Load while busy: load din=8'h10, then pulse load with din=8'hFF during EMIT and during DONE -> only code 4 is emitted, count=1.
- Reset mid-stream: din=8'hF0, accept one code, then pulse rst_n low asynchronously between edges -> outputs clear immediately, no done pulse, next load works normally.
